// File: rtl/clock_divider.sv
// Programmable clock divider with glitch-free runtime reconfiguration.
// Optional period counter output enabled by defining CLOCK_DIV_COUNT_EN.
module clock_divider #(
    parameter int W        = 16,
    parameter int DIV_RST  = 4,
    parameter int HIGH_RST = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_cfg_valid,
    input  logic [W-1:0] i_cfg_div,
    input  logic [W-1:0] i_cfg_high,
    output logic         o_cfg_ready,
    output logic         o_cfg_err,
    output logic         o_clk,
    output logic         o_roll_over
`ifdef CLOCK_DIV_COUNT_EN
    ,
    output logic [W-1:0] o_period_cnt
`endif
);

    function automatic logic [W-1:0] resolve_high(
        input logic [W-1:0] div,
        input logic [W-1:0] high
    );
        logic [W-1:0] r;
        if (high == '0)
            r = div >> 1;
        else if (high >= div)
            r = div - W'(1);
        else
            r = high;
        return r;
    endfunction

    localparam logic [W-1:0] DIV0  = W'(DIV_RST);
    localparam logic [W-1:0] HIGH0 = resolve_high(DIV0, W'(HIGH_RST));

    logic [W-1:0] div_q, div_d;
    logic [W-1:0] high_q, high_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pdiv_q, pdiv_d;
    logic [W-1:0] phigh_q, phigh_d;
    logic         pend_q, pend_d;
    logic         err_q, err_d;
    logic         clk_q, clk_d;
    logic         wrap;
    logic         roll;
    logic         accept;
    logic         apply;

    always_comb begin
        wrap    = (cnt_q == div_q - W'(1));
        roll    = i_en && wrap;
        accept  = i_cfg_valid && !pend_q;
        apply   = pend_q && (!i_en || wrap);
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        err_d   = 1'b0;

        if (accept) begin
            if (i_cfg_div < W'(2)) begin
                err_d = 1'b1;
            end else begin
                pend_d  = 1'b1;
                pdiv_d  = i_cfg_div;
                phigh_d = resolve_high(i_cfg_div, i_cfg_high);
            end
        end

        if (apply) begin
            div_d  = pdiv_q;
            high_d = phigh_q;
            pend_d = 1'b0;
        end

        cnt_d = (!i_en || wrap) ? '0 : cnt_q + W'(1);
        // Compare against next-state values so o_clk stays in phase with the counter
        clk_d = !i_en || (cnt_d < high_d);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_q   <= DIV0;
            high_q  <= HIGH0;
            cnt_q   <= '0;
            pdiv_q  <= '0;
            phigh_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            clk_q   <= 1'b1;
        end else begin
            div_q   <= div_d;
            high_q  <= high_d;
            cnt_q   <= cnt_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            clk_q   <= clk_d;
        end
    end

`ifdef CLOCK_DIV_COUNT_EN
    logic [W-1:0] pcnt_q, pcnt_d;

    always_comb begin
        pcnt_d = pcnt_q;
        if (apply)
            pcnt_d = '0;
        else if (roll)
            pcnt_d = pcnt_q + W'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_d;
    end

    assign o_period_cnt = pcnt_q;
`endif

    assign o_cfg_ready = !pend_q;
    assign o_cfg_err   = err_q;
    assign o_clk       = clk_q;
    assign o_roll_over = roll;

endmodule
